// File: rtl/ber_checker.sv
// PRBS7 (x^7+x^6+1) bit-error-rate checker: seed, hunt for lock, then flywheel-compare the stream.
// ERR and counters are registered (one cycle after the valid bit); DIN_VALID=0 stalls everything.
module ber_checker #(
   parameter int CW       = 16,
   parameter int BW       = 32,
   parameter int LOCK_N   = 32,
   parameter int UNLOCK_N = 8,
   parameter int WIN      = 64
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          DIN,
   input  logic          DIN_VALID,
   input  logic          CLR,
   output logic          ERR,
   output logic          LOCK,
   output logic [CW-1:0] ERR_CNT,
   output logic [BW-1:0] BIT_CNT
);

   typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

   localparam logic [7:0] LOCK_N_L   = 8'(LOCK_N);
   localparam logic [5:0] UNLOCK_N_L = 6'(UNLOCK_N);
   localparam logic [7:0] WIN_L      = 8'(WIN);

   state_t          state_q, state_d;
   logic [6:0]      lfsr_q, lfsr_d;
   logic [2:0]      seed_cnt_q, seed_cnt_d;
   logic [7:0]      run_cnt_q, run_cnt_d;
   logic [7:0]      win_bit_q, win_bit_d;
   logic [5:0]      win_err_q, win_err_d;
   logic            err_q, err_d;
   logic [CW-1:0]   err_cnt_q, err_cnt_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            pred;
   logic            mis;

   assign pred = lfsr_q[6] ^ lfsr_q[5];
   assign mis  = DIN ^ pred;

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      seed_cnt_d = seed_cnt_q;
      run_cnt_d  = run_cnt_q;
      win_bit_d  = win_bit_q;
      win_err_d  = win_err_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      bit_cnt_d  = bit_cnt_q;

      if (DIN_VALID) begin
         case (state_q)
            SEED: begin
               lfsr_d = {lfsr_q[5:0], DIN};
               if (seed_cnt_q == 3'd6) begin
                  seed_cnt_d = 3'd0;
                  state_d    = HUNT;
               end else begin
                  seed_cnt_d = seed_cnt_q + 3'd1;
               end
            end
            HUNT: begin
               lfsr_d = {lfsr_q[5:0], DIN};
               if (mis) begin
                  run_cnt_d = 8'd0;
               end else if (run_cnt_q == LOCK_N_L - 8'd1) begin
                  run_cnt_d = 8'd0;
                  state_d   = LOCKED;
               end else begin
                  run_cnt_d = run_cnt_q + 8'd1;
               end
            end
            LOCKED: begin
               // Flywheel: the LFSR runs on its own prediction, so errors do not corrupt it.
               lfsr_d = {lfsr_q[5:0], pred};
               err_d  = mis;
               if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
               if (mis && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
               win_bit_d = win_bit_q + 8'd1;
               win_err_d = win_err_q + {5'd0, mis};
               if (win_err_d == UNLOCK_N_L) begin
                  state_d    = SEED;
                  seed_cnt_d = 3'd0;
                  run_cnt_d  = 8'd0;
                  win_bit_d  = 8'd0;
                  win_err_d  = 6'd0;
               end else if (win_bit_d == WIN_L) begin
                  win_bit_d = 8'd0;
                  win_err_d = 6'd0;
               end
            end
            default: state_d = SEED;
         endcase
      end

      if (CLR) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= SEED;
         lfsr_q     <= 7'd0;
         seed_cnt_q <= 3'd0;
         run_cnt_q  <= 8'd0;
         win_bit_q  <= 8'd0;
         win_err_q  <= 6'd0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         seed_cnt_q <= seed_cnt_d;
         run_cnt_q  <= run_cnt_d;
         win_bit_q  <= win_bit_d;
         win_err_q  <= win_err_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign ERR     = err_q;
   assign LOCK    = (state_q == LOCKED);
   assign ERR_CNT = err_cnt_q;
   assign BIT_CNT = bit_cnt_q;

endmodule
